mem_req_ctrl: RTL and testbench

//  Request front-end for the single-port synchronous memory. Accepts one read/write request at a time on a

---
 rtl/mem_req_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - request front-end for a single-port synchronous memory
// One request in flight, range-checked, one-cycle memory strobe, one response per request.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ERRW       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid_out,
  output logic [ERRW-1:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ERRW-1:0]       ERR_MAX = {ERRW{1'b1}};

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ERRW-1:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          rsp_wr_d    = req_wr;
          rsp_rdata_d = '0;
          // Full-width unsigned compare so high address bits cannot alias into range.
          if (req_addr >= DEPTH_A) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            rsp_err_d   = 1'b0;
            mem_en_d    = 1'b1;
            mem_wr_d    = req_wr;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      ISSUE: begin
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        if (rsp_wr_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~mem_valid_out;
        rsp_rdata_d = mem_valid_out ? mem_rdata : '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          if (rsp_err_q && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl
// Table-driven transactions against a behavioural memory, plus hand-written corner sequences.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid_out;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;
  logic force_invalid = 1'b0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid_out(mem_valid_out), .err_cnt(err_cnt)
  );

  // Single-port synchronous memory: read data and valid_out appear one edge after en.
  logic [31:0] mem_array [0:31];
  always @(posedge clk) begin
    if (rst) begin
      mem_valid_out <= 1'b0;
      mem_rdata     <= '0;
    end else begin
      mem_valid_out <= mem_en && !mem_wr && !force_invalid;
      if (mem_en && mem_wr) mem_array[mem_addr[4:0]] <= mem_wdata;
      if (mem_en && !mem_wr) mem_rdata <= mem_array[mem_addr[4:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle. lat = edges after the accept edge
  // before rsp_valid is seen high (error 0, write 1, read 2).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic en_first, output int en_cnt,
                         output logic r_wr, output logic r_err, output logic [31:0] r_rdata);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    en_first = mem_en;
    en_cnt = int'(mem_en);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      en_cnt += int'(mem_en);
    end
    r_wr = rsp_wr; r_err = rsp_err; r_rdata = rsp_rdata;
    @(posedge clk); #1;
    en_cnt += int'(mem_en);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat, en_cnt;
    logic en_first, r_wr, r_err;
    logic [31:0] r_rdata, held;
    int guard;

    vecs[0]  = '{1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'h0,        1};
    vecs[1]  = '{1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b0, 32'd32,        32'h0,        1'b1, 32'h0,        0};
    vecs[3]  = '{1'b1, 32'd0,         32'h12345678, 1'b0, 32'h0,        1};
    vecs[4]  = '{1'b1, 32'd31,        32'hA5A55A5A, 1'b0, 32'h0,        1};
    vecs[5]  = '{1'b0, 32'd31,        32'h0,        1'b0, 32'hA5A55A5A, 2};
    vecs[6]  = '{1'b1, 32'd33,        32'hFFFFFFFF, 1'b1, 32'h0,        0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'h0,        1'b1, 32'h0,        0};
    vecs[8]  = '{1'b0, 32'h80000005,  32'h0,        1'b1, 32'h0,        0};
    vecs[9]  = '{1'b0, 32'd0,         32'h0,        1'b0, 32'h12345678, 2};
    vecs[10] = '{1'b1, 32'd32,        32'h11111111, 1'b1, 32'h0,        0};
    vecs[11] = '{1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 2};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err",   rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_en",    mem_en, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_err_cnt",   err_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, en_first, en_cnt, r_wr, r_err, r_rdata);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_en_first", i), en_first, !vecs[i].exp_err);
      chk($sformatf("v%0d_en_cnt", i), en_cnt, vecs[i].exp_err ? 0 : 1);
      chk($sformatf("v%0d_rsp_wr", i), r_wr, vecs[i].wr);
      chk($sformatf("v%0d_rsp_err", i), r_err, vecs[i].exp_err);
      chk($sformatf("v%0d_rsp_rdata", i), r_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_idle", i), {req_ready, rsp_valid}, 2'b10);
      if (vecs[i].exp_err) exp_errs++;
      chk($sformatf("v%0d_err_cnt", i), err_cnt, exp_errs);
    end

    // Backpressure: response must hold steady while rsp_ready is low.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("bp_rsp_valid", rsp_valid, 1);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b0, held});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", {rsp_valid, req_ready}, 2'b01);

    // Memory reports no valid data: read turns into an error with zero data.
    force_invalid = 1'b1;
    run_txn(1'b0, 32'd5, 32'h0, lat, en_first, en_cnt, r_wr, r_err, r_rdata);
    force_invalid = 1'b0;
    exp_errs++;
    chk("inv_lat", lat, 2);
    chk("inv_err_rdata", {r_err, r_rdata}, {1'b1, 32'h0});
    chk("inv_err_cnt", err_cnt, exp_errs);

    // Reset while waiting for read data.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst", {rsp_valid, mem_en, req_ready, err_cnt}, {1'b0, 1'b0, 1'b1, 8'd0});
    rst = 1'b0;
    exp_errs = 0;
    @(posedge clk); #1;
    run_txn(1'b0, 32'd5, 32'h0, lat, en_first, en_cnt, r_wr, r_err, r_rdata);
    chk("post_rst_read", {r_err, r_rdata}, {1'b0, 32'hDEADBEEF});
    chk("post_rst_lat", lat, 2);

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      run_txn(1'b0, 32'd100 + k, 32'h0, lat, en_first, en_cnt, r_wr, r_err, r_rdata);
      if (k == 254) chk("sat_at_255", err_cnt, 255);
    end
    chk("sat_err_cnt", err_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
